load_store_ctrl: RTL and testbench

//  Initiator side of the word-addressed data-memory interface (address/memRead/memWrite/

---
 rtl/load_store_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_load_store_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_ctrl.sv
// -----------------------------------------------------------------------------
// load_store_ctrl
//   Initiator side of a word-addressed data-memory interface, placed between
//   the MIPS MEM stage and data memory. Accepts lw/lh/lhu/lb/lbu/sw/sh/sb
//   requests, drives the memRead/memWrite handshake and returns extracted,
//   extended load data. Sub-word stores are read-modify-write. Memory reacts
//   to address changes, so every access phase is bracketed by PARK_ADDR.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake; ready only in IDLE
//   req_write         1 = store, 0 = load
//   req_size          00 byte, 01 half, 10/11 word
//   req_unsigned      loads: 1 = zero-extend, 0 = sign-extend
//   req_addr          byte address
//   req_wdata         store data, right-justified for sub-word stores
//   resp_valid        one-cycle completion pulse
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_error        misaligned or out-of-range access
//   busy              ~req_ready
//   mem_address       word index, or PARK_ADDR when idle
//   mem_read/write    memRead / memWrite strobes
//   mem_write_data    writeData
//   mem_read_data     readData
// -----------------------------------------------------------------------------
module load_store_ctrl #(
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned MEM_WORDS   = 51,
   parameter logic [31:0] PARK_ADDR   = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic        busy,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_PARK,
      S_WR,
      S_RESP
   } state_e;

   localparam int unsigned     CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

   // Big-endian lane extraction with sign/zero extension.
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      h = off[1] ? w[15:0] : w[31:16];
      case (sz)
         2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   // Replace only the addressed lane(s) of the old word with store data.
   function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                         input logic [1:0] sz, input logic [1:0] off);
      logic [31:0] r;
      r = w;
      case (sz)
         2'b00: begin
            case (off)
               2'd0:    r[31:24] = d[7:0];
               2'd1:    r[23:16] = d[7:0];
               2'd2:    r[15:8]  = d[7:0];
               default: r[7:0]   = d[7:0];
            endcase
         end
         2'b01: begin
            if (off[1]) r[15:0]  = d[15:0];
            else        r[31:16] = d[15:0];
         end
         default: r = d;
      endcase
      return r;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [29:0]      word_q;
   logic [1:0]       off_q, size_q;
   logic             uns_q, write_q, err_q;
   logic [31:0]      wdata_q, merge_q;

   logic             resp_valid_q, resp_valid_d;
   logic             resp_error_q, resp_error_d;
   logic [31:0]      resp_rdata_q, resp_rdata_d;
   logic [31:0]      mem_address_q, mem_address_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic [31:0]      mem_write_data_q, mem_write_data_d;

   logic             accept, acc_err, rd_done;
   logic [29:0]      cur_word;

   assign req_ready = (state_q == S_IDLE);
   assign busy      = ~req_ready;
   assign accept    = req_valid & req_ready;
   assign rd_done   = (cnt_q == CNT_LAST);

   // Misaligned half/word or word index beyond the memory depth.
   assign acc_err = (req_size == 2'b01 && req_addr[0])
                  || (req_size[1] && req_addr[1:0] != 2'b00)
                  || ({2'b00, req_addr[31:2]} >= MEM_WORDS);

   // On the acceptance edge the request fields are not yet captured.
   assign cur_word = (state_q == S_IDLE) ? req_addr[31:2] : word_q;

   // ---------------------------------------------------------------- state reg
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // --------------------------------------------------------------- next state
   // NOTE: default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (acc_err)                           state_d = S_PARK;
               else if (!req_write || !req_size[1])   state_d = S_RD;
               else                                   state_d = S_WR;
            end
         end
         S_RD:    if (rd_done) state_d = write_q ? S_PARK : S_RESP;
         // Errors also pass through PARK so the response timing matches the
         // one-cycle accesses while the memory port stays parked.
         S_PARK:  state_d = err_q ? S_RESP : S_WR;
         S_WR:    state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- output decode
   // Outputs are decoded from the next state and registered.
   always_comb begin
      mem_address_d    = PARK_ADDR;
      mem_read_d       = 1'b0;
      mem_write_d      = 1'b0;
      mem_write_data_d = '0;
      resp_valid_d     = 1'b0;
      resp_error_d     = 1'b0;
      resp_rdata_d     = '0;
      case (state_d)
         S_RD: begin
            mem_address_d = {2'b00, cur_word};
            mem_read_d    = 1'b1;
         end
         S_WR: begin
            mem_address_d    = {2'b00, cur_word};
            mem_write_d      = 1'b1;
            mem_write_data_d = (state_q == S_IDLE) ? req_wdata : merge_q;
         end
         S_RESP: begin
            resp_valid_d = 1'b1;
            resp_error_d = err_q;
            // Only a load reaches RESP straight from RD.
            if (state_q == S_RD) resp_rdata_d = extract(mem_read_data, size_q, off_q, uns_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_q     <= 1'b0;
         resp_error_q     <= 1'b0;
         resp_rdata_q     <= '0;
         mem_address_q    <= PARK_ADDR;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         mem_write_data_q <= '0;
      end else begin
         resp_valid_q     <= resp_valid_d;
         resp_error_q     <= resp_error_d;
         resp_rdata_q     <= resp_rdata_d;
         mem_address_q    <= mem_address_d;
         mem_read_q       <= mem_read_d;
         mem_write_q      <= mem_write_d;
         mem_write_data_q <= mem_write_data_d;
      end
   end

   // ----------------------------------------------------------------- datapath
   // NOTE: the request/data registers are reset too; they are few and this
   // keeps simulation free of X after an aborted operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         word_q  <= '0;
         off_q   <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         merge_q <= '0;
      end else begin
         if (accept) begin
            word_q  <= req_addr[31:2];
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            write_q <= req_write;
            err_q   <= acc_err;
            wdata_q <= req_wdata;
         end
         if (state_q == S_RD && !rd_done) cnt_q <= cnt_q + 1'b1;
         else                             cnt_q <= '0;
         if (state_q == S_RD && rd_done && write_q)
            merge_q <= merge(mem_read_data, wdata_q, size_q, off_q);
      end
   end

   assign resp_valid     = resp_valid_q;
   assign resp_error     = resp_error_q;
   assign resp_rdata     = resp_rdata_q;
   assign mem_address    = mem_address_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// -----------------------------------------------------------------------------
// tb_load_store_ctrl
//   Directed bench for load_store_ctrl. Two instances share the request bus:
//   u_dut1 (MEM_LATENCY=1) and u_dut3 (MEM_LATENCY=3), each with its own
//   word memory model. 'sel' picks which instance a task talks to.
// -----------------------------------------------------------------------------
module tb_load_store_ctrl;

   localparam logic [31:0] PARK = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] exp;
   } ld_vec_t;

   // word 3 = 0x80FF7F01
   localparam ld_vec_t LD_VEC [8] = '{
      '{2'b00, 1'b0, 32'h0C, 32'hFFFF_FF80},
      '{2'b00, 1'b1, 32'h0C, 32'h0000_0080},
      '{2'b01, 1'b0, 32'h0E, 32'h0000_7F01},
      '{2'b01, 1'b1, 32'h0C, 32'h0000_80FF},
      '{2'b01, 1'b0, 32'h0C, 32'hFFFF_80FF},
      '{2'b00, 1'b0, 32'h0D, 32'hFFFF_FFFF},
      '{2'b00, 1'b1, 32'h0F, 32'h0000_0001},
      '{2'b00, 1'b0, 32'h0E, 32'h0000_007F}
   };

   logic        clk, rst_n;
   logic        req_valid1, req_valid3, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;

   logic        ready1, rv1, err1, busy1, mr1, mw1;
   logic [31:0] rd1, ma1, wd1, mrd1;
   logic        ready3, rv3, err3, busy3, mr3, mw3;
   logic [31:0] rd3, ma3, wd3, mrd3;

   logic [31:0] mem1 [0:63];
   logic [31:0] mem3 [0:63];

   logic        sel;
   logic        cur_ready, cur_rv, cur_err, cur_busy, cur_mr, cur_mw;
   logic [31:0] cur_rd, cur_ma, cur_wd;

   int errors = 0;
   int checks = 0;
   int viol   = 0;

   load_store_ctrl #(.MEM_LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(ready1),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv1),
      .resp_rdata(rd1), .resp_error(err1), .busy(busy1), .mem_address(ma1),
      .mem_read(mr1), .mem_write(mw1), .mem_write_data(wd1), .mem_read_data(mrd1)
   );

   load_store_ctrl #(.MEM_LATENCY(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(ready3),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rv3),
      .resp_rdata(rd3), .resp_error(err3), .busy(busy3), .mem_address(ma3),
      .mem_read(mr3), .mem_write(mw3), .mem_write_data(wd3), .mem_read_data(mrd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memories: combinational read, write on the clock edge.
   assign mrd1 = (ma1 < 32'd51) ? mem1[ma1[5:0]] : 32'h0;
   assign mrd3 = (ma3 < 32'd51) ? mem3[ma3[5:0]] : 32'h0;
   always @(posedge clk) begin
      if (mw1 && ma1 < 32'd51) mem1[ma1[5:0]] = wd1;
      if (mw3 && ma3 < 32'd51) mem3[ma3[5:0]] = wd3;
   end

   // Handshake rules: never read+write together, never strobe on a parked address.
   always @(negedge clk) begin
      if (rst_n) begin
         if ((mr1 && mw1) || (ma1 == PARK && (mr1 || mw1))) viol++;
         if ((mr3 && mw3) || (ma3 == PARK && (mr3 || mw3))) viol++;
      end
   end

   assign cur_ready = sel ? ready3 : ready1;
   assign cur_rv    = sel ? rv3    : rv1;
   assign cur_err   = sel ? err3   : err1;
   assign cur_busy  = sel ? busy3  : busy1;
   assign cur_mr    = sel ? mr3    : mr1;
   assign cur_mw    = sel ? mw3    : mw1;
   assign cur_rd    = sel ? rd3    : rd1;
   assign cur_ma    = sel ? ma3    : ma1;
   assign cur_wd    = sel ? wd3    : wd1;

   // Drive one request; returns #1 after the acceptance edge E0.
   task automatic start_req(input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] pre_addr);
      @(negedge clk);
      req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      for (int i = 0; i < 20 && !cur_ready; i++) @(negedge clk);
      checks++;
      if (cur_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_timeout: req_ready=%b required 1", cur_ready);
      end
      pre_addr = cur_ma;
      if (sel) req_valid3 = 1'b1; else req_valid1 = 1'b1;
      @(posedge clk); #1;
      req_valid1 = 1'b0; req_valid3 = 1'b0;
      req_addr = 32'h5555_5555; req_wdata = 32'hA5A5_A5A5;   // ignored while busy
   endtask

   // Wait for resp_valid; lat = edges after E0. 'touched' = any mem strobe seen.
   task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er,
                            output logic touched);
      lat = 0; rd = '0; er = 1'b0; touched = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         touched = touched | cur_mr | cur_mw;
         @(posedge clk); #1;
         if (cur_rv) begin
            lat = i; rd = cur_rd; er = cur_err;
            break;
         end
      end
      checks++;
      if (lat == 0) begin
         errors++;
         $display("FAIL resp_timeout: resp_valid=%b required 1 within 20 cycles", cur_rv);
      end
   endtask

   task automatic do_access(input logic wr, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output int lat, output logic [31:0] rd, output logic er,
                            output logic touched, output logic [31:0] pre_addr);
      start_req(wr, sz, uns, addr, wd, pre_addr);
      wait_resp(lat, rd, er, touched);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid1 = 1'b0; req_valid3 = 1'b0; req_write = 1'b0; req_size = 2'b10;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; sel = 1'b0;
      for (int i = 0; i < 64; i++) begin mem1[i] = '0; mem3[i] = '0; end
      repeat (2) @(posedge clk); #1;
      checks++;
      if ({ready1, busy1, ready3, busy3} !== 4'b1010) begin
         errors++; $display("FAIL reset_ready: got %b required 1010", {ready1, busy1, ready3, busy3});
      end
      checks++;
      if ({rv1, err1, mr1, mw1} !== 4'b0000) begin
         errors++; $display("FAIL reset_strobes: got %b required 0000", {rv1, err1, mr1, mw1});
      end
      checks++;
      if (ma1 !== PARK || ma3 !== PARK) begin
         errors++; $display("FAIL reset_addr: got %h/%h required %h", ma1, ma3, PARK);
      end
      checks++;
      if (rd1 !== 32'h0 || wd1 !== 32'h0) begin
         errors++; $display("FAIL reset_data: rdata %h wdata %h required 0", rd1, wd1);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ready1 !== 1'b1 || rv1 !== 1'b0 || ma1 !== PARK) begin
         errors++; $display("FAIL post_reset_idle: ready %b rv %b addr %h required 1 0 %h",
                            ready1, rv1, ma1, PARK);
      end
   endtask

   task automatic test_load_word();
      logic [31:0] pre;
      sel = 1'b0;
      mem1[2] = 32'h1122_3344;
      start_req(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, pre);
      checks++;
      if (ma1 !== 32'd2 || mr1 !== 1'b1 || mw1 !== 1'b0 || busy1 !== 1'b1) begin
         errors++; $display("FAIL lw_rd_phase: addr %h rd %b wr %b busy %b required 2 1 0 1",
                            ma1, mr1, mw1, busy1);
      end
      @(posedge clk); #1;
      checks++;
      if (rv1 !== 1'b1 || rd1 !== 32'h1122_3344 || err1 !== 1'b0) begin
         errors++; $display("FAIL lw_resp: rv %b data %h err %b required 1 11223344 0", rv1, rd1, err1);
      end
      checks++;
      if (ma1 !== PARK || mr1 !== 1'b0) begin
         errors++; $display("FAIL lw_park: addr %h rd %b required %h 0", ma1, mr1, PARK);
      end
      @(posedge clk); #1;
      checks++;
      if (rv1 !== 1'b0 || ready1 !== 1'b1) begin
         errors++; $display("FAIL lw_pulse: rv %b ready %b required 0 1", rv1, ready1);
      end
   endtask

   task automatic test_load_extend();
      int lat; logic [31:0] rd, pre; logic er, t;
      sel = 1'b0;
      mem1[3] = 32'h80FF_7F01;
      for (int i = 0; i < 8; i++) begin
         do_access(1'b0, LD_VEC[i].sz, LD_VEC[i].uns, LD_VEC[i].addr, 32'h0, lat, rd, er, t, pre);
         checks++;
         if (rd !== LD_VEC[i].exp || er !== 1'b0 || lat != 1) begin
            errors++; $display("FAIL load_ext[%0d]: data %h err %b lat %0d required %h 0 1",
                               i, rd, er, lat, LD_VEC[i].exp);
         end
      end
   endtask

   task automatic test_subword_store();
      int lat; logic [31:0] rd, pre; logic er, t;
      sel = 1'b0;
      mem1[2] = 32'h1122_3344;
      start_req(1'b1, 2'b00, 1'b0, 32'h0A, 32'h1234_56AB, pre);
      checks++;
      if (ma1 !== 32'd2 || mr1 !== 1'b1 || mw1 !== 1'b0) begin
         errors++; $display("FAIL sb_rd: addr %h rd %b wr %b required 2 1 0", ma1, mr1, mw1);
      end
      @(posedge clk); #1;
      checks++;
      if (ma1 !== PARK || mr1 !== 1'b0 || mw1 !== 1'b0 || rv1 !== 1'b0) begin
         errors++; $display("FAIL sb_park: addr %h rd %b wr %b rv %b required %h 0 0 0",
                            ma1, mr1, mw1, rv1, PARK);
      end
      @(posedge clk); #1;
      checks++;
      if (ma1 !== 32'd2 || mw1 !== 1'b1 || mr1 !== 1'b0 || wd1 !== 32'h1122_AB44) begin
         errors++; $display("FAIL sb_wr: addr %h wr %b rd %b data %h required 2 1 0 1122ab44",
                            ma1, mw1, mr1, wd1);
      end
      @(posedge clk); #1;
      checks++;
      if (rv1 !== 1'b1 || err1 !== 1'b0 || rd1 !== 32'h0 || ma1 !== PARK || mw1 !== 1'b0) begin
         errors++; $display("FAIL sb_resp: rv %b err %b data %h addr %h wr %b required 1 0 0 %h 0",
                            rv1, err1, rd1, ma1, mw1, PARK);
      end
      checks++;
      if (mem1[2] !== 32'h1122_AB44) begin
         errors++; $display("FAIL sb_mem: word2 %h required 1122ab44", mem1[2]);
      end
      do_access(1'b1, 2'b01, 1'b0, 32'h08, 32'hFFFF_CAFE, lat, rd, er, t, pre);
      checks++;
      if (mem1[2] !== 32'hCAFE_AB44 || lat != 3 || er !== 1'b0) begin
         errors++; $display("FAIL sh_merge: word2 %h lat %0d err %b required cafeab44 3 0",
                            mem1[2], lat, er);
      end
      do_access(1'b1, 2'b00, 1'b0, 32'h0B, 32'h0000_0001, lat, rd, er, t, pre);
      checks++;
      if (mem1[2] !== 32'hCAFE_AB01) begin
         errors++; $display("FAIL sb_lane3: word2 %h required cafeab01", mem1[2]);
      end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd, pre; logic er, t;
      logic        ewr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [1:0]  esz [5] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
      logic [31:0] ead [5] = '{32'h03, 32'hCC, 32'h0A, 32'hCC, 32'h05};
      sel = 1'b0;
      for (int i = 0; i < 5; i++) begin
         do_access(ewr[i], esz[i], 1'b0, ead[i], 32'hFFFF_FFFF, lat, rd, er, t, pre);
         checks++;
         if (er !== 1'b1 || lat != 1 || t !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL err[%0d]: err %b lat %0d touched %b data %h required 1 1 0 0",
                               i, er, lat, t, rd);
         end
      end
      checks++;
      if (mem1[2] !== 32'hCAFE_AB01) begin
         errors++; $display("FAIL err_no_write: word2 %h required cafeab01", mem1[2]);
      end
      mem1[50] = 32'h5A5A_0050;
      do_access(1'b0, 2'b10, 1'b0, 32'hC8, 32'h0, lat, rd, er, t, pre);
      checks++;
      if (er !== 1'b0 || rd !== 32'h5A5A_0050 || lat != 1) begin
         errors++; $display("FAIL last_word: err %b data %h lat %0d required 0 5a5a0050 1", er, rd, lat);
      end
      do_access(1'b0, 2'b11, 1'b0, 32'h0C, 32'h0, lat, rd, er, t, pre);
      checks++;
      if (er !== 1'b0 || rd !== 32'h80FF_7F01) begin
         errors++; $display("FAIL size11_word: err %b data %h required 0 80ff7f01", er, rd);
      end
   endtask

   task automatic test_back_to_back();
      int lat; logic [31:0] rd, pre; logic er, t;
      sel = 1'b0;
      do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er, t, pre);
      checks++;
      if (lat != 1 || er !== 1'b0 || mem1[4] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL sw_l1: lat %0d err %b word4 %h required 1 0 deadbeef", lat, er, mem1[4]);
      end
      do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, t, pre);
      checks++;
      if (pre !== PARK || lat != 1 || rd !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL b2b_l1: pre_addr %h lat %0d data %h required %h 1 deadbeef",
                            pre, lat, rd, PARK);
      end
      sel = 1'b1;
      do_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er, t, pre);
      checks++;
      if (lat != 1 || mem3[4] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL sw_l3: lat %0d word4 %h required 1 deadbeef", lat, mem3[4]);
      end
      do_access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, t, pre);
      checks++;
      if (pre !== PARK || lat != 3 || rd !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL b2b_l3: pre_addr %h lat %0d data %h required %h 3 deadbeef",
                            pre, lat, rd, PARK);
      end
      do_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_0000, lat, rd, er, t, pre);
      checks++;
      if (lat != 5 || mem3[4] !== 32'hDE00_BEEF) begin
         errors++; $display("FAIL sb_l3: lat %0d word4 %h required 5 de00beef", lat, mem3[4]);
      end
      sel = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd, pre; logic er, t;
      sel = 1'b0;
      mem1[5] = 32'h0BAD_F00D;
      start_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, pre);
      checks++;
      if (busy1 !== 1'b1 || mr1 !== 1'b1) begin
         errors++; $display("FAIL mid_in_rd: busy %b rd %b required 1 1", busy1, mr1);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (ma1 !== PARK || mr1 !== 1'b0 || rv1 !== 1'b0 || ready1 !== 1'b1) begin
         errors++; $display("FAIL mid_reset: addr %h rd %b rv %b ready %b required %h 0 0 1",
                            ma1, mr1, rv1, ready1, PARK);
      end
      @(negedge clk); rst_n = 1'b1;
      t = 1'b0;
      repeat (3) begin @(posedge clk); #1; t = t | rv1; end
      checks++;
      if (t !== 1'b0) begin
         errors++; $display("FAIL mid_no_resp: resp_valid seen %b required 0", t);
      end
      do_access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, rd, er, t, pre);
      checks++;
      if (rd !== 32'h0BAD_F00D || lat != 1 || er !== 1'b0) begin
         errors++; $display("FAIL after_reset_lw: data %h lat %0d err %b required 0badf00d 1 0", rd, lat, er);
      end
   endtask

   task automatic test_protocol();
      checks++;
      if (viol != 0) begin
         errors++; $display("FAIL protocol: violations %0d required 0", viol);
      end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_extend();
      test_subword_store();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_protocol();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
